register_file_unit: RTL



---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_init_sweeper.sv | 35 +++
 rtl/register_file_unit.sv | 69 ++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared register-file types and defaults: widths, the hardwired zero index, and sweep FSM states.
package rf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic [0:0] {
    RF_INIT  = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_init_sweeper.sv
// Post-reset clear sequencer: it emits one zero-write address per cycle for 2**ADDR_WIDTH cycles.
// regFileReady rises on the edge that clears the last entry. There is no backpressure, and reset restarts the sweep.
module rf_init_sweeper
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  sweepWe,
  output logic [ADDR_WIDTH-1:0] sweepAddr,
  output logic                  regFileReady
);

  rf_state_t             state;
  logic [ADDR_WIDTH-1:0] sweepPtr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RF_INIT;
      sweepPtr <= '0;
    end else if (state == RF_INIT) begin
      // The pointer wraps to 0 on the final clear, so it is clean if reset re-enters INIT later.
      sweepPtr <= sweepPtr + 1'b1;
      if (sweepPtr == {ADDR_WIDTH{1'b1}}) begin
        state <= RF_READY;
      end
    end
  end

  assign sweepWe      = (state == RF_INIT) && !reset;
  assign sweepAddr    = sweepPtr;
  assign regFileReady = (state == RF_READY);

endmodule

// File: rtl/register_file_unit.sv
// 32-entry GPR file with two combinational read ports, one synchronous write port and a hardwired zero in r0.
// Storage is cleared by a sweep after reset. Reads return 0 and writes are dropped until regFileReady is high.
module register_file_unit
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH,
  parameter bit BYPASS_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] readReg1,
  input  logic [ADDR_WIDTH-1:0] readReg2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  regFileReady
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  sweepWe;
  logic [ADDR_WIDTH-1:0] sweepAddr;
  logic                  userWe;

  rf_init_sweeper #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sweeper (
    .clk          (clk),
    .reset        (reset),
    .sweepWe      (sweepWe),
    .sweepAddr    (sweepAddr),
    .regFileReady (regFileReady)
  );

  assign userWe = regFileReady && !reset && regWrite && (writeReg != ZERO_IDX);

  // Single write port shared between the clear sweep and user writes, so the array stays BRAM/LUTRAM-friendly.
  always_ff @(posedge clk) begin
    if (sweepWe) begin
      mem[sweepAddr] <= '0;
    end else if (userWe) begin
      mem[writeReg] <= writeData;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] val;
    val = '0;
    if (!regFileReady || idx == ZERO_IDX) begin
      val = '0;
    end else if (BYPASS_EN && regWrite && writeReg == idx) begin
      val = writeData;
    end else begin
      val = mem[idx];
    end
    return val;
  endfunction

  always_comb begin
    readData1 = read_port(readReg1);
    readData2 = read_port(readReg2);
  end

endmodule
